controller_input: RTL and testbench
===================================

# controller_input

Game-side reader for the four HexDefenders GPIO player controllers. Each controller has 8 switches and 1 button on a 9-pin stride of the 36-pin GPIO header. The block synchronizes all pins and debounces each button. On every debounced press it captures that player's 8-bit switch value and delivers it to game logic as one event per press on a valid/ready stream, with round-robin arbitration across players. It also drives the constant controller supply-enable pins.

## Interface
Parameters:
- NUM_PLAYERS, 4, number of controllers; fixed at 4 by the pin map.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button state changes; 10 ms at 50 MHz; must be ≥ 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- gpins  in  36  raw header pins; player p: switches gpins[9p+7:9p], button gpins[9p+8], active-high.
- volts  out  2  controller supply enables; constant 2'b11, including during reset.
- sw_state  out  32  synchronized (not debounced) switches; player p at [8p+7:8p].
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_player  out  2  player index of the event.
- evt_value  out  8  switch value captured at the press.
- overrun  out  4  sticky per-player overrun flags; present only with CTRL_INPUT_OVERRUN_EN.
- clr_overrun  in  1  clears all overrun flags; present only with CTRL_INPUT_OVERRUN_EN.

## Operation
- Reset values:
  - All synchronizer flops, debounced states, counters, pending flags, output registers and overrun flags are 0.
  - Round-robin pointer is 0.
  - evt_valid=0, evt_player=0, evt_value=0, sw_state=0.
- Synchronizer: two flops per pin on all 36 pins.
- Debounce, per button:
  - A counter increments each cycle the synced value differs from the debounced state.
  - The counter clears on any cycle the two agree.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state takes the synced value and the counter clears.
- Press: debounced 0→1 transition. Releases generate nothing.
- Capture, in the cycle after the press:
  - pending_val[p] ← synced switches of p, sampled in the press cycle.
  - pending[p] ← 1.
- Press while pending[p]=1: the new press is dropped and the old value is retained.
- Arbiter:
  - Search order starts at the pointer and wraps modulo 4.
  - The first pending player found is granted.
  - After granting p, the pointer becomes (p+1) mod 4.
- Output stage load condition: evt_valid=0, or evt_valid&&evt_ready, with at least one pending player.
- On load:
  - evt_player/evt_value come from the granted player.
  - evt_valid=1.
  - pending[granted] clears in the same cycle.
- If the load condition holds but nothing is pending, evt_valid goes to 0 at the next edge.
- Set/clear collision: a capture for p in the same cycle that p's pending slot is loaded out sets pending[p] again (set wins), holding the new value.
- Stream rule: while evt_valid=1 and evt_ready=0, evt_player and evt_value are held stable.

## Timing
- Latency with an empty output and no competing players: a button edge held stable at gpins produces evt_valid after exactly 2 (sync) + DEBOUNCE_CYCLES + 2 (capture, load) rising edges.
- Throughput: one event per cycle when evt_ready is held high.
- Reset may assert asynchronously at any point, including mid-debounce or mid-handshake. It aborts immediately; events pending at that time are lost.

## Configuration
- CTRL_INPUT_OVERRUN_EN defined:
  - Ports overrun and clr_overrun exist.
  - A dropped press sets overrun[p].
  - clr_overrun=1 clears all four flags at the next edge; a drop in that same cycle leaves its flag set.
- CTRL_INPUT_OVERRUN_EN undefined: both ports and all associated logic are absent, and drops are silent.

## Structure
- Package ctrl_pkg contains:
  - NUM_PLAYERS=4, SW_W=8, PIN_STRIDE=9, PLAYER_W=2.
  - Typedef ctrl_evt_t {player, value}.
- Sub-module ctrl_debounce holds one button's counter and debounced state, with outputs state and rise. It is instantiated NUM_PLAYERS times with a $clog2(DEBOUNCE_CYCLES+1)-bit counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold rst_n=0 with random gpins → evt_valid=0, sw_state=0, volts=2'b11. After release, sw_state tracks gpins 2 cycles later.
- Single press: set player 2 switches to 8'hA5, then raise gpins[26] and hold, with evt_ready=1 → evt_valid rises at edge 8 for exactly one cycle with evt_player=2, evt_value=8'hA5.
- Bounce: toggle gpins[8] every 2 cycles for 20 cycles, then hold 0 → no event.
- Simultaneous presses on all four players with evt_ready=0 for 10 cycles, then 1 → events arrive in player order 0,1,2,3 and are stable while stalled.
- Overrun (CTRL_INPUT_OVERRUN_EN): player 1 presses twice with evt_ready=0 → one event with the first value; overrun=4'b0010 until clr_overrun pulses.
- Reset mid-handshake: assert rst_n=0 while evt_valid=1 → evt_valid=0 immediately; no stale event after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and event type for the HexDefenders controller reader.
//   NUM_PLAYERS  number of controllers on the GPIO header
//   SW_W         switches per controller
//   PIN_STRIDE   header pins per controller (switches + button)
//   PLAYER_W     width of a player index
package ctrl_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned SW_W        = 8;
  localparam int unsigned PIN_STRIDE  = 9;
  localparam int unsigned PLAYER_W    = 2;

  typedef struct packed {
    logic [PLAYER_W-1:0] player;
    logic [SW_W-1:0]     value;
  } ctrl_evt_t;

endpackage

// File: rtl/ctrl_debounce.sv
// ctrl_debounce: counter-based debouncer for one synchronized button.
//   clk, rst_n  clock, asynchronous active-low reset
//   btn         synchronized button level
//   state       debounced button level
//   rise        one-cycle pulse in the cycle after state goes 0->1
module ctrl_debounce
  import ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic state,
  output logic rise
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (btn == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == LastCnt) begin
        // This edge makes the count reach DEBOUNCE_CYCLES: accept the new level.
        r_state <= btn;
        r_cnt   <= '0;
        r_rise  <= btn;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign state = r_state;
  assign rise  = r_rise;

endmodule

// File: rtl/controller_input.sv
// controller_input: reads four GPIO player controllers (8 switches + 1 button each),
// synchronizes all pins, debounces buttons and emits one {player, switches} event per
// press on a valid/ready stream with round-robin arbitration.
//   clk, rst_n            clock, asynchronous active-low reset
//   gpins[35:0]           raw header pins; player p: sw [9p+7:9p], button [9p+8]
//   volts[1:0]            controller supply enables, constant 2'b11
//   sw_state[31:0]        synchronized switches, player p at [8p+7:8p]
//   evt_valid/evt_ready   event handshake
//   evt_player, evt_value event payload
//   overrun, clr_overrun  sticky drop flags and clear (only with CTRL_INPUT_OVERRUN_EN)
// Optional feature macro: CTRL_INPUT_OVERRUN_EN.
module controller_input
  import ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS     = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] gpins,
  output logic [1:0]  volts,
  output logic [31:0] sw_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_player,
  output logic [7:0]  evt_value
`ifdef CTRL_INPUT_OVERRUN_EN
  ,
  output logic [3:0]  overrun,
  input  logic        clr_overrun
`endif
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [35:0] r_sync1, r_sync2;

  logic [NUM_PLAYERS-1:0][SW_W-1:0] w_sw;
  logic [NUM_PLAYERS-1:0]           w_btn, w_db_state, w_rise, w_press;

  logic [NUM_PLAYERS-1:0]           r_pending;
  logic [NUM_PLAYERS-1:0][SW_W-1:0] r_pending_val;
  logic [PLAYER_W-1:0]              r_ptr;
  logic                             r_valid;
  ctrl_evt_t                        r_evt;

  logic                             w_load, w_take, w_gnt_found;
  logic [PLAYER_W-1:0]              w_gnt, w_idx;
  logic [NUM_PLAYERS-1:0]           w_clr, w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpins;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign w_sw[p]  = r_sync2[p*PIN_STRIDE +: SW_W];
    assign w_btn[p] = r_sync2[p*PIN_STRIDE + SW_W];

    ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CntW)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (w_btn[p]),
      .state(w_db_state[p]),
      .rise (w_rise[p])
    );
  end

  // rise already implies state=1; the AND keeps a press tied to the debounced level.
  assign w_press = w_rise & w_db_state;

  // Round-robin search starting at the pointer; the 2-bit index wraps modulo 4.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt       = '0;
    w_idx       = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_idx = r_ptr + PLAYER_W'(i);
      if (!w_gnt_found && r_pending[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt       = w_idx;
      end
    end
  end

  assign w_load = !r_valid || evt_ready;
  assign w_take = w_load && w_gnt_found;

  // A slot being loaded out this cycle may be refilled by a same-cycle capture.
  always_comb begin
    w_clr    = '0;
    w_accept = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_clr[p]    = w_take && (w_gnt == PLAYER_W'(p));
      w_accept[p] = w_press[p] && (!r_pending[p] || w_clr[p]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= '0;
      r_pending_val <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_accept;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_accept[p]) r_pending_val[p] <= w_sw[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_evt   <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid      <= 1'b1;
      r_evt.player <= w_gnt;
      r_evt.value  <= r_pending_val[w_gnt];
      r_ptr        <= w_gnt + PLAYER_W'(1);
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

`ifdef CTRL_INPUT_OVERRUN_EN
  logic [NUM_PLAYERS-1:0] w_drop;
  logic [NUM_PLAYERS-1:0] r_overrun;

  assign w_drop = w_press & r_pending & ~w_clr;

  // A drop in the clearing cycle still sets its flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (clr_overrun ? '0 : r_overrun) | w_drop;
    end
  end

  assign overrun = r_overrun;
`endif

  assign volts      = 2'b11;
  assign sw_state   = w_sw;
  assign evt_valid  = r_valid;
  assign evt_player = r_evt.player;
  assign evt_value  = r_evt.value;

endmodule

// File: tb/tb_controller_input.sv
// tb_controller_input: self-checking bench for controller_input with DEBOUNCE_CYCLES=4.
// Directed vectors and sequences followed by randomized presses checked against
// per-player expected-value queues.
module tb_controller_input;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] gpins = '0;
  logic [1:0]  volts;
  logic [31:0] sw_state;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_player;
  logic [7:0]  evt_value;
`ifdef CTRL_INPUT_OVERRUN_EN
  logic [3:0]  overrun;
  logic        clr_overrun = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_en   = 1'b0;
  bit mon_en   = 1'b0;

  logic [7:0] exp_q[4][$];

  controller_input #(
    .NUM_PLAYERS    (4),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gpins     (gpins),
    .volts     (volts),
    .sw_state  (sw_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_player(evt_player),
    .evt_value (evt_value)
`ifdef CTRL_INPUT_OVERRUN_EN
    ,
    .overrun   (overrun),
    .clr_overrun(clr_overrun)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) evt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_sw(input int p, input logic [7:0] v);
    gpins[p*9 +: 8] = v;
  endtask

  task automatic set_btn(input int p, input logic b);
    gpins[p*9 + 8] = b;
  endtask

  // Waits (bounded) for evt_valid; returns whether it was seen.
  task automatic wait_valid(input int budget, output bit seen);
    int w = 0;
    while (!evt_valid && w < budget) begin
      tick();
      w++;
    end
    seen = evt_valid;
  endtask

  // Monitor for the random phase: every accepted event must be the oldest
  // outstanding press of its player; a stalled event must not change.
  logic        prev_stall = 1'b0;
  logic [10:0] prev_bus   = '0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_stall) chk("rnd_stable", {evt_valid, evt_player, evt_value}, prev_bus);
      if (evt_valid && evt_ready) begin
        chk("rnd_evt_expected", exp_q[evt_player].size() != 0, 1);
        if (exp_q[evt_player].size() != 0) chk("rnd_value", evt_value, exp_q[evt_player].pop_front());
      end
      prev_stall <= evt_valid && !evt_ready;
      prev_bus   <= {evt_valid, evt_player, evt_value};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0]  sw0, sw1, sw2, sw3;
    logic [31:0] exp_sw;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] r64;
    logic [1:0]  got_p[8];
    logic [7:0]  got_v[8];
    logic [7:0]  exp_v[4];
    int          cnt, first, idx;
    logic [1:0]  pl0;
    logic [7:0]  v0;
    bit          seen;

    vecs[0] = '{8'hFF, 8'h00, 8'h00, 8'h00, 32'h0000_00FF, 1'b0};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'h00, 32'h0000_FF00, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h7856_3412, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC3_5AA5, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h0100_0000, 1'b0};
    exp_v   = '{8'h10, 8'h21, 8'h32, 8'h43};

    // Reset with random pins
    r64   = {$urandom(), $urandom()};
    gpins = r64[35:0];
    #12;
    chk("rst_valid", evt_valid, 0);
    chk("rst_sw_state", sw_state, 0);
    chk("rst_volts", volts, 2'b11);
    chk("rst_player_value", {evt_player, evt_value}, 0);
`ifdef CTRL_INPUT_OVERRUN_EN
    chk("rst_overrun", overrun, 0);
`endif
    gpins = '0;
    set_sw(0, 8'h11); set_sw(1, 8'h22); set_sw(2, 8'h33); set_sw(3, 8'h44);
    tick();
    rst_n = 1'b1;
    tick();
    chk("sync_1edge", sw_state, 0);
    tick();
    chk("sync_2edge", sw_state, 32'h4433_2211);

    // Table-driven switch vectors
    for (int i = 0; i < 6; i++) begin
      set_sw(0, vecs[i].sw0); set_sw(1, vecs[i].sw1);
      set_sw(2, vecs[i].sw2); set_sw(3, vecs[i].sw3);
      tick();
      tick();
      chk($sformatf("vec%0d_sw_state", i), sw_state, vecs[i].exp_sw);
      chk($sformatf("vec%0d_valid", i), evt_valid, vecs[i].exp_valid);
    end

    // Single press latency
    evt_ready = 1'b1;
    gpins     = '0;
    set_sw(2, 8'hA5);
    repeat (3) tick();
    set_btn(2, 1'b1);
    first = 0; cnt = 0; pl0 = '0; v0 = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (evt_valid) begin
        if (first == 0) begin
          first = k; pl0 = evt_player; v0 = evt_value;
        end
        cnt++;
      end
    end
    chk("single_edge", first, 8);
    chk("single_cycles", cnt, 1);
    chk("single_player", pl0, 2);
    chk("single_value", v0, 8'hA5);
    set_btn(2, 1'b0);
    repeat (12) tick();
    chk("single_release_quiet", evt_valid, 0);

    // Bounce: toggling every 2 cycles never settles
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) gpins[8] = ~gpins[8];
      tick();
      if (evt_valid) cnt++;
    end
    gpins[8] = 1'b0;
    repeat (30) begin
      tick();
      if (evt_valid) cnt++;
    end
    chk("bounce_no_event", cnt, 0);

    // Simultaneous presses, stalled, after reset so the pointer starts at 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    evt_ready = 1'b0;
    for (int p = 0; p < 4; p++) set_sw(p, exp_v[p]);
    repeat (3) tick();
    for (int p = 0; p < 4; p++) set_btn(p, 1'b1);
    wait_valid(20, seen);
    chk("simul_valid", seen, 1);
    pl0 = evt_player;
    v0  = evt_value;
    chk("simul_first_player", pl0, 0);
    chk("simul_first_value", v0, exp_v[0]);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("simul_stall_stable", {evt_valid, evt_player, evt_value}, {1'b1, pl0, v0});
    end
    evt_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (evt_valid && idx < 8) begin
        got_p[idx] = evt_player; got_v[idx] = evt_value; idx++;
      end
      tick();
    end
    chk("simul_count", idx, 4);
    for (int i = 0; i < 4 && i < idx; i++) begin
      chk($sformatf("simul_order%0d", i), {got_p[i], got_v[i]}, {i[1:0], exp_v[i]});
    end
    gpins = '0;
    repeat (12) tick();

    // Overrun: output busy with player 0, player 1 presses twice
    evt_ready = 1'b0;
    set_sw(0, 8'h77);
    repeat (3) tick();
    set_btn(0, 1'b1);
    wait_valid(20, seen);
    chk("ovr_p0_valid", seen, 1);
    set_btn(0, 1'b0);
    repeat (12) tick();
    set_sw(1, 8'h5C);
    repeat (3) tick();
    set_btn(1, 1'b1);
    repeat (10) tick();
    set_btn(1, 1'b0);
    repeat (12) tick();
    set_sw(1, 8'hC3);
    repeat (3) tick();
    set_btn(1, 1'b1);
    repeat (10) tick();
    set_btn(1, 1'b0);
    repeat (12) tick();
    chk("ovr_held", {evt_valid, evt_player, evt_value}, {1'b1, 2'd0, 8'h77});
`ifdef CTRL_INPUT_OVERRUN_EN
    chk("ovr_flag", overrun, 4'b0010);
`endif
    evt_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (evt_valid && idx < 8) begin
        got_p[idx] = evt_player; got_v[idx] = evt_value; idx++;
      end
      tick();
    end
    chk("ovr_count", idx, 2);
    chk("ovr_evt1", {got_p[1], got_v[1]}, {2'd1, 8'h5C});
`ifdef CTRL_INPUT_OVERRUN_EN
    chk("ovr_flag_sticky", overrun, 4'b0010);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 4'b0000);
`endif

    // Reset mid-handshake
    evt_ready = 1'b0;
    set_sw(3, 8'h99);
    repeat (3) tick();
    set_btn(3, 1'b1);
    wait_valid(20, seen);
    chk("rstmid_valid", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_clear", evt_valid, 0);
    gpins = '0;
    tick();
    tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (evt_valid) cnt++;
    end
    chk("rstmid_no_stale", cnt, 0);

    // Randomized presses against per-player expected queues
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [3:0] mask;
      logic [7:0] vals[4];
      int         off[4];
      mask = 4'($urandom_range(1, 15));
      for (int p = 0; p < 4; p++) begin
        vals[p] = 8'($urandom());
        off[p]  = $urandom_range(0, 3);
        set_sw(p, vals[p]);
      end
      repeat (3) tick();
      for (int t = 0; t < 4; t++) begin
        for (int p = 0; p < 4; p++) begin
          if (mask[p] && off[p] == t) begin
            set_btn(p, 1'b1);
            exp_q[p].push_back(vals[p]);
          end
        end
        tick();
      end
      repeat (10) tick();
      for (int p = 0; p < 4; p++) set_btn(p, 1'b0);
      repeat (14) tick();
    end
    rnd_en    = 1'b0;
    evt_ready = 1'b1;
    repeat (20) tick();
    mon_en = 1'b0;
    chk("rnd_all_delivered",
        exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
`ifdef CTRL_INPUT_OVERRUN_EN
    chk("rnd_no_overrun", overrun, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
